// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide front end.
//   - md_state_e : sequencing states of hilo_unit
//   - XLEN_DEF   : default operand / HI / LO width
//   - TIMEOUT_DEF: default watchdog limit in cycles
//   - wd_width() : counter width able to hold 0..timeout
package md_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait
  } md_state_e;

  function automatic int unsigned wd_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/md_watchdog.sv
// Cycle watchdog for an in-flight multiply.
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   clr     : synchronous clear of the count (wins over en)
//   en      : count this cycle
//   expired : high during the TIMEOUT-th counted cycle; the owner aborts at that edge
module md_watchdog
  import md_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = wd_width(TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Count starts at 0 in the first counted cycle, so count == TIMEOUT-1 marks the
  // TIMEOUT-th cycle spent in LAUNCH+WAIT.
  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner sitting between the control unit and the Booth multiplier.
// Latches MULT operands, runs the start/busy handshake, captures the product,
// services MTHI/MTLO, and aborts a hung multiply via a watchdog.
// Ports:
//   clk, reset           : clock (rising edge), async active-low reset
//   start, op_a, op_b    : one-cycle MULT request with operands
//   mthi_we, mtlo_we     : HI/LO writes from wdata
//   mul_x, mul_y         : latched operands to the multiplier
//   mul_start, mul_clear : multiplier start level / active-high multiplier reset
//   mul_busy             : multiplier busy
//   mul_hi, mul_lo       : multiplier product
//   hi_q, lo_q           : architectural HI/LO
//   busy, done           : stall request / one-cycle capture pulse
//   timeout_err          : sticky watchdog abort flag
//   hazard_err           : sticky flag for MTHI/MTLO while busy
// TIMEOUT must exceed the multiplier latency (> 36) or every multiply aborts.
module hilo_unit
  import md_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            mthi_we,
  input  logic            mtlo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] mul_x,
  output logic [XLEN-1:0] mul_y,
  output logic            mul_start,
  output logic            mul_clear,
  input  logic            mul_busy,
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] mul_lo,
  output logic [XLEN-1:0] hi_q,
  output logic [XLEN-1:0] lo_q,
  output logic            busy,
  output logic            done,
  output logic            timeout_err,
  output logic            hazard_err
);

  md_state_e       state_q, state_d;
  logic [XLEN-1:0] hi_d, lo_d, x_d, y_d;
  logic            start_d, done_d, abort_q, abort_d, terr_d, herr_d;
  logic            wd_clr, wd_en, wd_expired;

  md_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign wd_en = (state_q != StIdle);
  assign busy  = (state_q != StIdle);
  // Held during reset so the multiplier never leaves reset with a stale busy;
  // pulsed for one cycle after a watchdog abort.
  assign mul_clear = ~reset | abort_q;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    x_d     = mul_x;
    y_d     = mul_y;
    start_d = mul_start;
    done_d  = 1'b0;
    abort_d = 1'b0;
    terr_d  = timeout_err;
    herr_d  = hazard_err;
    wd_clr  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;
        if (start) begin
          x_d     = op_a;
          y_d     = op_b;
          start_d = 1'b1;
          wd_clr  = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        if (wd_expired) begin
          abort_d = 1'b1;
        end else if (mul_busy) begin
          // The multiplier re-arms on a high start level once idle, so drop it now.
          start_d = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A product arriving on the last allowed cycle is still taken.
        if (!mul_busy) begin
          hi_d    = mul_hi;
          lo_d    = mul_lo;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (wd_expired) begin
          abort_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_d) begin
      state_d = StIdle;
      start_d = 1'b0;
      terr_d  = 1'b1;
    end

    // HI/LO writes are dropped while a product is pending.
    if ((state_q != StIdle) && (mthi_we || mtlo_we)) herr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      hi_q        <= '0;
      lo_q        <= '0;
      mul_x       <= '0;
      mul_y       <= '0;
      mul_start   <= 1'b0;
      done        <= 1'b0;
      abort_q     <= 1'b0;
      timeout_err <= 1'b0;
      hazard_err  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mul_x       <= x_d;
      mul_y       <= y_d;
      mul_start   <= start_d;
      done        <= done_d;
      abort_q     <= abort_d;
      timeout_err <= terr_d;
      hazard_err  <= herr_d;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a behavioural Booth multiplier model.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        mthi_we, mtlo_we;
  logic [31:0] wdata;
  logic [31:0] mul_x, mul_y;
  logic        mul_start, mul_clear;
  logic        mul_busy;
  logic [31:0] mul_hi, mul_lo;
  logic [31:0] hi_q, lo_q;
  logic        busy, done, timeout_err, hazard_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hilo_unit #(
    .XLEN    (32),
    .TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .mthi_we     (mthi_we),
    .mtlo_we     (mtlo_we),
    .wdata       (wdata),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_start   (mul_start),
    .mul_clear   (mul_clear),
    .mul_busy    (mul_busy),
    .mul_hi      (mul_hi),
    .mul_lo      (mul_lo),
    .hi_q        (hi_q),
    .lo_q        (lo_q),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .hazard_err  (hazard_err)
  );

  // Multiplier model: starts on a start level while idle, busy rises after the
  // next edge and falls 32 cycles later. hang freezes it busy.
  logic        m_busy;
  logic [5:0]  m_cnt;
  logic [63:0] m_prod;
  logic        hang = 1'b0;

  always_ff @(posedge clk) begin
    if (mul_clear) begin
      m_busy <= 1'b0;
      m_cnt  <= 6'd0;
      m_prod <= 64'd0;
    end else if (m_busy) begin
      if (!hang) begin
        if (m_cnt == 6'd0) m_busy <= 1'b0;
        else m_cnt <= m_cnt - 6'd1;
      end
    end else if (mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 6'd31;
      m_prod <= $signed({{32{mul_x[31]}}, mul_x}) * $signed({{32{mul_y[31]}}, mul_y});
    end
  end

  assign mul_busy = m_busy;
  assign mul_hi   = m_prod[63:32];
  assign mul_lo   = m_prod[31:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  int  n;
  logic seen_done;

  initial begin
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_hi", hi_q, 0);
    check("rst_lo", lo_q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_clear", mul_clear, 1);
    check("rst_errs", {timeout_err, hazard_err}, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("post_rst_clear", mul_clear, 0);

    // 7 x -3
    op_a = 32'h0000_0007; op_b = 32'hFFFF_FFFD; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_mul_x", mul_x, 32'h7);
    check("t1_mul_y", mul_y, 32'hFFFF_FFFD);
    check("t1_mul_start", mul_start, 1);
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (i == 1 || i == 33) check("t1_busy_hold", {busy, done}, 2'b10);
      if (i == 2) check("t1_start_drop", mul_start, 0);
    end
    tick();
    check("t1_done", {busy, done}, 2'b01);
    check("t1_hi", hi_q, 32'hFFFF_FFFF);
    check("t1_lo", lo_q, 32'hFFFF_FFEB);
    tick();
    check("t1_done_pulse", done, 0);

    // 0x10000 squared, with an ignored second start
    op_a = 32'h0001_0000; op_b = 32'h0001_0000; start = 1'b1;
    tick();
    op_a = 32'hDEAD_0000; op_b = 32'hBEEF_0000;
    tick();
    start = 1'b0;
    tick();
    check("t2_mul_x_stable", mul_x, 32'h0001_0000);
    check("t2_mul_y_stable", mul_y, 32'h0001_0000);
    wait_done(n);
    check("t2_done", done, 1);
    check("t2_hi", hi_q, 32'h1);
    check("t2_lo", lo_q, 32'h0);
    tick();
    check("t2_no_restart", busy, 0);

    // MTHI / MTLO
    mthi_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    mthi_we = 1'b0;
    check("t3_mthi_hi", hi_q, 32'h1234_5678);
    check("t3_mthi_lo", lo_q, 32'h0);
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h0BAD_F00D;
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    check("t3_both", {hi_q, lo_q}, 64'h0BAD_F00D_0BAD_F00D);
    op_a = 32'd2; op_b = 32'd3; start = 1'b1; mthi_we = 1'b1; wdata = 32'h55;
    tick();
    start = 1'b0; mthi_we = 1'b0;
    check("t3_start_mthi", hi_q, 32'h55);
    repeat (5) tick();
    mtlo_we = 1'b1; wdata = 32'hFFFF_0000;
    tick();
    mtlo_we = 1'b0;
    check("t3_mtlo_dropped", lo_q, 32'h0BAD_F00D);
    check("t3_hazard", hazard_err, 1);
    wait_done(n);
    check("t3_done", done, 1);
    check("t3_capture", {hi_q, lo_q}, 64'h0000_0000_0000_0006);
    check("t3_hazard_sticky", hazard_err, 1);

    // Hung multiplier -> watchdog abort
    hang = 1'b1;
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; seen_done = 1'b0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (done) seen_done = 1'b1;
    end
    check("t4_cycles", n, 64);
    check("t4_clear", mul_clear, 1);
    check("t4_start_low", mul_start, 0);
    check("t4_terr", timeout_err, 1);
    check("t4_no_done", seen_done, 0);
    check("t4_hilo_kept", {hi_q, lo_q}, 64'h0000_0000_0000_0006);
    hang = 1'b0;
    tick();
    check("t4_clear_pulse", mul_clear, 0);
    check("t4_model_cleared", mul_busy, 0);
    check("t4_terr_sticky", timeout_err, 1);

    // Reset mid-operation, then 3 x 5
    op_a = 32'd2; op_b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check("t5_in_wait", {busy, mul_start}, 2'b10);
    reset = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_hilo", {hi_q, lo_q}, 0);
    check("t5_rst_mul", {mul_x, mul_y}, 0);
    check("t5_rst_flags", {mul_start, done, timeout_err, hazard_err}, 0);
    check("t5_rst_clear", mul_clear, 1);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("t5_no_stale_busy", {mul_busy, busy}, 0);
    op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("t5_latency", n, 34);
    check("t5_capture", {hi_q, lo_q}, 64'h0000_0000_0000_000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Owns the architectural HI/LO registers of the multicycle processor.
- Sits between the control unit and the multicycle Booth multiplier: latches the MULT operands, drives the multiplier start/busy handshake, and captures the 64-bit product into HI/LO.
- Services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.
- Gives the control unit a single stall signal and a watchdog so a hung multiply cannot lock the datapath.

Parameters:
- XLEN, 32, data width of operands and of HI/LO.
- TIMEOUT, 64, max cycles from launch to product capture before abort (must be > 36).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle MULT request from the control unit.
- op_a  in  XLEN  multiplicand (rs), sampled with start.
- op_b  in  XLEN  multiplier (rt), sampled with start.
- mthi_we  in  1  write HI from wdata.
- mtlo_we  in  1  write LO from wdata.
- wdata  in  XLEN  MTHI/MTLO data.
- mul_x  out  XLEN  latched op_a to the multiplier.
- mul_y  out  XLEN  latched op_b to the multiplier.
- mul_start  out  1  multiplier start level (its mult_control).
- mul_clear  out  1  active-high multiplier reset.
- mul_busy  in  1  multiplier busy (its operando).
- mul_hi  in  XLEN  multiplier product, high word.
- mul_lo  in  XLEN  multiplier product, low word.
- hi_q  out  XLEN  HI register.
- lo_q  out  XLEN  LO register.
- busy  out  1  stall request to the control unit; high when state != IDLE.
- done  out  1  one-cycle pulse when HI/LO are loaded from a product.
- timeout_err  out  1  sticky watchdog flag.
- hazard_err  out  1  sticky flag: MTHI/MTLO attempted while busy.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; hi_q, lo_q, mul_x, mul_y = 0.
  - mul_start, done, timeout_err, hazard_err = 0.
  - mul_clear=1, combinational while reset is low.
- FSM states: IDLE, LAUNCH, WAIT. All registers update on the clk rising edge.
- IDLE:
  - start=1 at edge k: mul_x<=op_a, mul_y<=op_b, mul_start<=1, watchdog cleared, state<=LAUNCH.
  - mthi_we / mtlo_we write hi_q / lo_q at the same edge, independent of start.
- LAUNCH:
  - mul_start held at 1 until mul_busy=1 is sampled; then mul_start<=0, state<=WAIT.
  - mul_start must drop, because the multiplier restarts if the start level stays high while it is idle.
- WAIT:
  - On the first edge sampling mul_busy=0: hi_q<=mul_hi, lo_q<=mul_lo, done<=1 for one cycle, state<=IDLE.
- Latency with the current multiplier: start at edge k → mul_busy rises after k+1 → LAUNCH→WAIT at k+2 → mul_busy falls after k+33 → hi_q/lo_q/done valid after edge k+34. busy=1 from after k through k+33.
- mul_x/mul_y stay stable from launch until the next accepted start.
- Watchdog:
  - Counts cycles in LAUNCH+WAIT.
  - On reaching TIMEOUT: state<=IDLE, mul_start<=0, mul_clear=1 for exactly one cycle, timeout_err<=1, HI/LO unchanged, no done pulse.
- Ignored inputs: start while not IDLE is ignored (no queuing).
- MTHI/MTLO while not IDLE:
  - The write is dropped and hazard_err<=1.
  - The in-flight product still lands at capture.
- Simultaneous events:
  - start + mthi_we in IDLE: HI is written now; the later capture overwrites it.
  - mthi_we + mtlo_we together: both are written from wdata.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. mul_clear aborts the multiplier, so no stale busy is seen after release.
- Error flags: timeout_err and hazard_err clear only on reset.
- Sign handling: the block does no arithmetic; the multiplier owns signedness. HI/LO are stored bit-exact.

Decomposition:
- Package md_pkg:
  - State enum {IDLE, LAUNCH, WAIT}.
  - XLEN and TIMEOUT defaults.
  - Watchdog counter width = $clog2(TIMEOUT+1).
- Sub-module md_watchdog: counter with clear, enable and an expired output; instantiated once.

Test Plan:
- Multiplier model: the bench uses a behavioural model that matches the 33-cycle busy timing.
- 7 × −3 (op_a=0x00000007, op_b=0xFFFFFFFD), start at edge k → hi_q=0xFFFFFFFF, lo_q=0xFFFFFFEB, done pulse after edge k+34, busy high k..k+33.
- 0x00010000 × 0x00010000 → hi_q=0x00000001, lo_q=0x00000000; a second start issued during busy is ignored and mul_x stays 0x00010000.
- IDLE, mthi_we=1, wdata=0x12345678 → hi_q=0x12345678 next edge, lo_q unchanged; mtlo_we during WAIT → lo_q unchanged, hazard_err=1.
- Model holds mul_busy=1 forever → after 64 cycles in LAUNCH+WAIT: state IDLE, timeout_err=1, one-cycle mul_clear, HI/LO retain prior values.
- Reset asserted 10 cycles into WAIT → all outputs 0 immediately, mul_clear=1; after release a fresh 3 × 5 gives hi_q=0, lo_q=0x0000000F.
